// File: rtl/panda_alu_arbiter.sv
// Round-robin arbiter sharing one combinational panda_alu between NumReq requesters,
// with a registered, valid/ready result slot per requester.

package panda_pkg;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA,
      ALU_EQ, ALU_NE, ALU_LT, ALU_LTU, ALU_GE, ALU_GEU
   } alu_operator_e;
endpackage

// One result slot: a grant loads the ALU result, a pop clears it, grant wins on overlap.
module panda_alu_arbiter_slot (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        grant_i,
   input  logic        pop_i,
   input  logic [31:0] result_i,
   output logic        valid_o,
   output logic [31:0] result_o
);
   logic        valid_d, valid_q;
   logic [31:0] result_d, result_q;

   always_comb begin
      valid_d  = valid_q;
      result_d = result_q;
      if (pop_i) valid_d = 1'b0;
      if (grant_i) begin
         valid_d  = 1'b1;
         result_d = result_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q  <= 1'b0;
         result_q <= '0;
      end else begin
         valid_q  <= valid_d;
         result_q <= result_d;
      end
   end

   assign valid_o  = valid_q;
   assign result_o = result_q;
endmodule

// NumReq is legal in 2..4.
module panda_alu_arbiter import panda_pkg::*; #(
   parameter int unsigned NumReq = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic          [NumReq-1:0]      req_valid_i,
   output logic          [NumReq-1:0]      req_ready_o,
   input  alu_operator_e [NumReq-1:0]      req_operator_i,
   input  logic          [NumReq-1:0][31:0] req_operand_a_i,
   input  logic          [NumReq-1:0][31:0] req_operand_b_i,
   output logic          [NumReq-1:0]      rsp_valid_o,
   input  logic          [NumReq-1:0]      rsp_ready_i,
   output logic          [NumReq-1:0][31:0] rsp_result_o,
   output alu_operator_e                   alu_operator_o,
   output logic          [31:0]            alu_operand_a_o,
   output logic          [31:0]            alu_operand_b_o,
   input  logic          [31:0]            alu_result_i,
   output logic          [NumReq-1:0]      busy_o
);
   localparam int unsigned PtrW = $clog2(NumReq);

   logic [PtrW-1:0]   rr_ptr_d, rr_ptr_q;
   logic [PtrW-1:0]   scan_idx, gnt_idx;
   logic [NumReq-1:0] eligible, grant;
   logic              gnt_any;

   // A slot being popped this cycle can take a new result on the same edge.
   assign eligible = req_valid_i & (~rsp_valid_o | rsp_ready_i);

   always_comb begin
      grant    = '0;
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      scan_idx = '0;
      for (int unsigned o = 0; o < NumReq; o++) begin
         scan_idx = PtrW'((32'(rr_ptr_q) + o) % NumReq);
         if (!gnt_any && eligible[scan_idx]) begin
            grant[scan_idx] = 1'b1;
            gnt_any         = 1'b1;
            gnt_idx         = scan_idx;
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt_any) rr_ptr_d = (gnt_idx == PtrW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rr_ptr_q <= '0;
      else         rr_ptr_q <= rr_ptr_d;
   end

   // Idle ALU inputs are parked at ADD 0,0 so they do not toggle.
   always_comb begin
      alu_operator_o  = ALU_ADD;
      alu_operand_a_o = '0;
      alu_operand_b_o = '0;
      if (gnt_any) begin
         alu_operator_o  = req_operator_i[gnt_idx];
         alu_operand_a_o = req_operand_a_i[gnt_idx];
         alu_operand_b_o = req_operand_b_i[gnt_idx];
      end
   end

   assign req_ready_o = grant;
   assign busy_o      = rsp_valid_o | req_valid_i;

   for (genvar i = 0; i < NumReq; i++) begin : g_slot
      panda_alu_arbiter_slot u_slot (
         .clk_i    (clk_i),
         .rst_ni   (rst_ni),
         .grant_i  (grant[i]),
         .pop_i    (rsp_ready_i[i]),
         .result_i (alu_result_i),
         .valid_o  (rsp_valid_o[i]),
         .result_o (rsp_result_o[i])
      );

      a_rsp_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
         rsp_valid_o[i] && !rsp_ready_i[i] |=> rsp_valid_o[i] && $stable(rsp_result_o[i]));

      a_req_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
         req_valid_i[i] && !req_ready_o[i] |=> req_valid_i[i] && $stable(req_operator_i[i]) &&
            $stable(req_operand_a_i[i]) && $stable(req_operand_b_i[i]));
   end

   a_one_grant : assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(req_ready_o & req_valid_i));

   a_no_full_grant : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_ready_o & rsp_valid_o & ~rsp_ready_i) == '0);
endmodule

// File: tb/tb_panda_alu_arbiter.sv
// Bench for panda_alu_arbiter: directed vector table, hand sequences for reset and
// the 3-port build, then random traffic against a behavioural model.
module tb_panda_alu_arbiter;
   import panda_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // 2-port instance
   logic [1:0]          rv, rr, rdy, vld, busy;
   alu_operator_e [1:0] op;
   logic [1:0][31:0]    a, b, res;
   alu_operator_e       alu_op;
   logic [31:0]         alu_a, alu_b, alu_res;

   // 3-port instance
   logic [2:0]          rv3, rr3, rdy3, vld3, busy3;
   alu_operator_e [2:0] op3;
   logic [2:0][31:0]    a3, b3, res3;
   alu_operator_e       alu_op3;
   logic [31:0]         alu_a3, alu_b3, alu_res3;

   int errors = 0;
   int checks = 0;

   function automatic logic [31:0] alu_ref(alu_operator_e o, logic [31:0] x, logic [31:0] y);
      case (o)
         ALU_ADD: return x + y;
         ALU_SUB: return x - y;
         ALU_XOR: return x ^ y;
         ALU_OR:  return x | y;
         ALU_AND: return x & y;
         ALU_SLL: return x << y[4:0];
         ALU_SRL: return x >> y[4:0];
         ALU_SRA: return 32'($signed(x) >>> y[4:0]);
         ALU_EQ:  return {31'b0, x == y};
         ALU_NE:  return {31'b0, x != y};
         ALU_LT:  return {31'b0, $signed(x) < $signed(y)};
         ALU_LTU: return {31'b0, x < y};
         ALU_GE:  return {31'b0, $signed(x) >= $signed(y)};
         ALU_GEU: return {31'b0, x >= y};
         default: return 32'h0;
      endcase
   endfunction

   // Shared combinational ALU seen by each arbiter.
   assign alu_res  = alu_ref(alu_op, alu_a, alu_b);
   assign alu_res3 = alu_ref(alu_op3, alu_a3, alu_b3);

   panda_alu_arbiter #(.NumReq(2)) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(rv), .req_ready_o(rdy), .req_operator_i(op),
      .req_operand_a_i(a), .req_operand_b_i(b),
      .rsp_valid_o(vld), .rsp_ready_i(rr), .rsp_result_o(res),
      .alu_operator_o(alu_op), .alu_operand_a_o(alu_a), .alu_operand_b_o(alu_b),
      .alu_result_i(alu_res), .busy_o(busy)
   );

   panda_alu_arbiter #(.NumReq(3)) u_dut3 (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(rv3), .req_ready_o(rdy3), .req_operator_i(op3),
      .req_operand_a_i(a3), .req_operand_b_i(b3),
      .rsp_valid_o(vld3), .rsp_ready_i(rr3), .rsp_result_o(res3),
      .alu_operator_o(alu_op3), .alu_operand_a_o(alu_a3), .alu_operand_b_o(alu_b3),
      .alu_result_i(alu_res3), .busy_o(busy3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rv = '0; rv3 = '0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit            rst;
      logic [1:0]    rv, rr;
      alu_operator_e op0, op1;
      logic [31:0]   a0, b0, a1, b1;
      logic [1:0]    e_rdy;
      alu_operator_e e_op;
      logic [31:0]   e_a, e_b;
      logic [1:0]    e_vld;
      logic [31:0]   e_r0, e_r1;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit r, logic [1:0] v, logic [1:0] p,
                               alu_operator_e o0, logic [31:0] x0, logic [31:0] y0,
                               alu_operator_e o1, logic [31:0] x1, logic [31:0] y1,
                               logic [1:0] erdy, alu_operator_e eop, logic [31:0] ea, logic [31:0] eb,
                               logic [1:0] evld, logic [31:0] er0, logic [31:0] er1);
      vec_t t;
      t.rst = r; t.rv = v; t.rr = p;
      t.op0 = o0; t.a0 = x0; t.b0 = y0; t.op1 = o1; t.a1 = x1; t.b1 = y1;
      t.e_rdy = erdy; t.e_op = eop; t.e_a = ea; t.e_b = eb;
      t.e_vld = evld; t.e_r0 = er0; t.e_r1 = er1;
      return t;
   endfunction

   initial begin
      vec_t v;
      logic [2:0] exp_g [4];
      int ptr;
      logic [1:0] mv, pend, exp_rdy;
      logic [1:0][31:0] mr;
      int gp;

      rv = '0; rr = '0; op = {ALU_ADD, ALU_ADD}; a = '0; b = '0;
      rv3 = '0; rr3 = '0; op3 = {ALU_ADD, ALU_ADD, ALU_ADD}; a3 = '0; b3 = '0;

      // Reset state
      #1;
      chk("rst_vld", 32'(vld), 32'h0);
      chk("rst_res0", res[0], 32'h0);
      chk("rst_res1", res[1], 32'h0);
      chk("rst_vld3", 32'(vld3), 32'h0);
      chk("rst_idle_op", 32'(alu_op), 32'(ALU_ADD));

      // single port
      tbl.push_back(mk(1, 2'b01, 2'b11, ALU_ADD, 5, 7, ALU_ADD, 0, 0, 2'b01, ALU_ADD, 5, 7, 2'b01, 12, 0));
      tbl.push_back(mk(0, 2'b00, 2'b11, ALU_ADD, 0, 0, ALU_ADD, 0, 0, 2'b00, ALU_ADD, 0, 0, 2'b00, 12, 0));
      // contention
      tbl.push_back(mk(1, 2'b11, 2'b11, ALU_ADD, 1, 1, ALU_SUB, 10, 3, 2'b01, ALU_ADD, 1, 1, 2'b01, 2, 0));
      tbl.push_back(mk(0, 2'b11, 2'b11, ALU_ADD, 1, 1, ALU_SUB, 10, 3, 2'b10, ALU_SUB, 10, 3, 2'b10, 2, 7));
      tbl.push_back(mk(0, 2'b11, 2'b11, ALU_ADD, 1, 1, ALU_SUB, 10, 3, 2'b01, ALU_ADD, 1, 1, 2'b01, 2, 7));
      tbl.push_back(mk(0, 2'b11, 2'b11, ALU_ADD, 1, 1, ALU_SUB, 10, 3, 2'b10, ALU_SUB, 10, 3, 2'b10, 2, 7));
      // backpressure on port0
      tbl.push_back(mk(0, 2'b01, 2'b10, ALU_ADD, 1, 1, ALU_SUB, 10, 3, 2'b01, ALU_ADD, 1, 1, 2'b01, 2, 7));
      tbl.push_back(mk(0, 2'b11, 2'b10, ALU_ADD, 1, 1, ALU_LTU, 3, 5, 2'b10, ALU_LTU, 3, 5, 2'b11, 2, 1));
      tbl.push_back(mk(0, 2'b11, 2'b10, ALU_ADD, 1, 1, ALU_LTU, 3, 5, 2'b10, ALU_LTU, 3, 5, 2'b11, 2, 1));
      tbl.push_back(mk(0, 2'b11, 2'b11, ALU_ADD, 1, 1, ALU_LTU, 3, 5, 2'b01, ALU_ADD, 1, 1, 2'b01, 2, 1));
      // back-to-back on port1
      tbl.push_back(mk(1, 2'b10, 2'b11, ALU_ADD, 0, 0, ALU_SLL, 1, 4, 2'b10, ALU_SLL, 1, 4, 2'b10, 0, 32'h10));
      tbl.push_back(mk(0, 2'b10, 2'b11, ALU_ADD, 0, 0, ALU_SRA, 32'h8000_0000, 4, 2'b10, ALU_SRA, 32'h8000_0000, 4, 2'b10, 0, 32'hF800_0000));
      tbl.push_back(mk(0, 2'b10, 2'b11, ALU_ADD, 0, 0, ALU_XOR, 32'hF0F0, 32'hFFFF, 2'b10, ALU_XOR, 32'hF0F0, 32'hFFFF, 2'b10, 0, 32'h0F0F));
      tbl.push_back(mk(0, 2'b00, 2'b11, ALU_ADD, 0, 0, ALU_ADD, 0, 0, 2'b00, ALU_ADD, 0, 0, 2'b00, 0, 32'h0F0F));

      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         if (v.rst) do_reset();
         @(negedge clk);
         rv = v.rv; rr = v.rr;
         op[0] = v.op0; a[0] = v.a0; b[0] = v.b0;
         op[1] = v.op1; a[1] = v.a1; b[1] = v.b1;
         #1;
         chk($sformatf("v%0d_rdy", i), 32'(rdy), 32'(v.e_rdy));
         chk($sformatf("v%0d_alu_op", i), 32'(alu_op), 32'(v.e_op));
         chk($sformatf("v%0d_alu_a", i), alu_a, v.e_a);
         chk($sformatf("v%0d_alu_b", i), alu_b, v.e_b);
         @(posedge clk); #1;
         chk($sformatf("v%0d_vld", i), 32'(vld), 32'(v.e_vld));
         chk($sformatf("v%0d_res0", i), res[0], v.e_r0);
         chk($sformatf("v%0d_res1", i), res[1], v.e_r1);
      end

      // Reset mid-operation with both slots full and the pointer left at port1
      do_reset();
      @(negedge clk);
      rr = 2'b00;
      op[0] = ALU_ADD; a[0] = 1; b[0] = 1;
      op[1] = ALU_SUB; a[1] = 10; b[1] = 3;
      rv = 2'b10;
      @(negedge clk);
      rv = 2'b01;
      @(negedge clk);
      rv = 2'b00;
      chk("mid_vld_full", 32'(vld), 32'h3);
      chk("mid_res0", res[0], 32'h2);
      chk("mid_res1", res[1], 32'h7);
      #2 rst_n = 1'b0;
      #1;
      chk("async_vld", 32'(vld), 32'h0);
      chk("async_res0", res[0], 32'h0);
      chk("async_res1", res[1], 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      rv = 2'b11; rr = 2'b11;
      #1;
      chk("post_rst_grant", 32'(rdy), 32'h1);
      @(posedge clk); #1;
      chk("post_rst_res0", res[0], 32'h2);

      // 3-port build
      do_reset();
      exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
      @(negedge clk);
      rr3 = 3'b111; rv3 = 3'b111;
      op3[0] = ALU_ADD; a3[0] = 1; b3[0] = 2;
      op3[1] = ALU_SUB; a3[1] = 5; b3[1] = 1;
      op3[2] = ALU_GE;  a3[2] = 32'hFFFF_FFFF; b3[2] = 1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("n3_grant%0d", k), 32'(rdy3), 32'(exp_g[k]));
         @(posedge clk); #1;
         if (k == 0) chk("n3_res0", res3[0], 32'd3);
         if (k == 1) chk("n3_res1", res3[1], 32'd4);
         if (k == 2) begin
            chk("n3_vld2", 32'(vld3[2]), 32'h1);
            chk("n3_res2_ge", res3[2], 32'h0);
         end
         @(negedge clk);
      end

      // Random traffic on the 2-port build against a slot/pointer model
      do_reset();
      ptr = 0; mv = '0; mr = '0; pend = '0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            if (!pend[p]) begin
               rv[p] = ($urandom_range(0, 3) != 0);
               op[p] = alu_operator_e'($urandom_range(0, 13));
               a[p]  = $urandom;
               b[p]  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
            end
         end
         rr = 2'($urandom);
         gp = -1;
         for (int o = 0; o < 2; o++) begin
            int p;
            p = (ptr + o) % 2;
            if (gp < 0 && rv[p] && (!mv[p] || rr[p])) gp = p;
         end
         exp_rdy = (gp >= 0) ? 2'(1 << gp) : 2'b00;
         #1;
         chk("rnd_rdy", 32'(rdy), 32'(exp_rdy));
         chk("rnd_busy", 32'(busy), 32'(mv | rv));
         chk("rnd_alu_op", 32'(alu_op), (gp >= 0) ? 32'(op[gp]) : 32'(ALU_ADD));
         chk("rnd_alu_a", alu_a, (gp >= 0) ? a[gp] : 32'h0);
         chk("rnd_alu_b", alu_b, (gp >= 0) ? b[gp] : 32'h0);
         mv = mv & ~rr;
         if (gp >= 0) begin
            mv[gp] = 1'b1;
            mr[gp] = alu_ref(op[gp], a[gp], b[gp]);
            ptr = (gp + 1) % 2;
         end
         pend = rv & ~exp_rdy;
         @(posedge clk); #1;
         chk("rnd_vld", 32'(vld), 32'(mv));
         chk("rnd_res0", res[0], mr[0]);
         chk("rnd_res1", res[1], mr[1]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/panda_alu_arbiter.md
Name: panda_alu_arbiter

Overview:
Shares one combinational panda_alu instance between NumReq requesters, e.g. the main execute stage and a multi-cycle mul/div or CSR helper. Arbitration is round-robin with a valid/ready request handshake. Each requester has its own registered result slot with a valid/ready response handshake. The arbiter drives the ALU operator and operand inputs and samples the ALU result in the same cycle, so the ALU stays purely combinational.

Parameters:
NumReq, 2, number of requesters; legal range 2..4.

Ports:
clk_i  input  1  clock; all state on rising edge
rst_ni  input  1  asynchronous, active-low reset
req_valid_i  input  NumReq  request valid, one bit per requester
req_ready_o  output  NumReq  request accepted this cycle when valid&ready
req_operator_i  input  NumReq x panda_pkg::alu_operator_e  requested operation
req_operand_a_i  input  NumReq x 32  operand A
req_operand_b_i  input  NumReq x 32  operand B
rsp_valid_o  output  NumReq  result slot holds an unconsumed result
rsp_ready_i  input  NumReq  requester consumes result when valid&ready
rsp_result_o  output  NumReq x 32  registered result per requester
alu_operator_o  output  alu_operator_e  to shared ALU operator_i
alu_operand_a_o  output  32  to shared ALU operand_a_i
alu_operand_b_o  output  32  to shared ALU operand_b_i
alu_result_i  input  32  from shared ALU result_o
busy_o  output  NumReq  rsp_valid_o OR pending request, per port (debug/perf)

Behaviour:
- Reset (async, rst_ni low):
  - rr_ptr = 0
  - rsp_valid_o = 0 and rsp_result_o = 0 for all ports
  - Any in-flight result is discarded; no response is produced for it after reset.
- Slot free for port i: ~rsp_valid_o[i] | rsp_ready_i[i]. A slot being popped this cycle counts as free.
- Eligible[i] = req_valid_i[i] & slot free[i].
- Grant:
  - At most one port is granted per cycle.
  - The first eligible port scanning rr_ptr, rr_ptr+1, ... modulo NumReq.
  - req_ready_o[i] = grant[i].
  - req_ready_o may depend combinationally on all req_valid_i and rsp_ready_i. It never depends on alu_result_i.
- Pointer update:
  - On accept by port k, rr_ptr <= (k+1) mod NumReq.
  - With no accept, rr_ptr holds.
- ALU drive:
  - With a grant, alu_* outputs = the granted port's operator and operands, same cycle.
  - With no grant, alu_* outputs = ALU_ADD, 0, 0 (deterministic, no toggling).
- Latency: on the accept edge, rsp_result_o[k] <= alu_result_i and rsp_valid_o[k] <= 1. The result is visible exactly 1 cycle after accept.
- Response hold: rsp_valid_o[i] and rsp_result_o[i] are stable until the cycle in which rsp_ready_i[i]=1. After that cycle rsp_valid_o[i] clears, unless a new accept for i happens in the same cycle.
- Simultaneous pop and accept on the same port: the new result overwrites the slot and rsp_valid_o stays 1. A single port sustains 1 op/cycle with rsp_ready_i tied high.
- Backpressure: a port with a full, unpopped slot is never granted. Other ports proceed; no head-of-line blocking.
- rsp_ready_i[i] while rsp_valid_o[i]=0 is ignored.
- Requester rule (checked by assertion): once req_valid_i[i]=1, it stays high with stable operator/operands until accepted. The arbiter does not rely on this for correctness.
- Comparison operators (EQ/NE/LT/LTU/GE/GEU) return the ALU's {31'b0, cmp} value unchanged. The arbiter never inspects the operator.
- Assertions:
  - $onehot0(req_ready_o & req_valid_i)
  - no grant to a port with a full slot
  - rsp_result_o stable while rsp_valid_o & ~rsp_ready_i

Test Plan:
- Single port: port0 requests ADD 5+7, rsp_ready=1. Accept in cycle 0, rsp_valid_o[0]=1 with 12 in cycle 1. ALU idles ADD,0,0 afterwards.
- Contention: both ports valid every cycle, all rsp_ready=1 (port0 ADD 1+1, port1 SUB 10-3). Grants alternate 0,1,0,1 starting at port0 after reset. Results are 2 and 7 alternately, each 1 cycle after its grant.
- Backpressure: port0 rsp_ready=0 after its first result (32'h2). Port0 req_ready stays 0 and rsp_result_o[0] holds 2. Port1 gets every grant, LTU 3<5 returns 1. Raising rsp_ready[0] regrants port0 in that same cycle.
- Back-to-back single port: port1 alone with rsp_ready=1 issues SLL 1<<4, SRA 0x80000000>>>4, XOR 0xF0F0^0xFFFF. Results 0x10, 0xF8000000, 0x0F0F on consecutive cycles, no bubbles.
- Reset mid-operation: pulse rst_ni low asynchronously while rsp_valid_o=2'b11. Outputs clear immediately without a clock edge. After release, the first grant with both valid goes to port0 (rr_ptr=0).
- NumReq=3 build: all three valid continuously. Grant sequence is 0,1,2,0. Port2 GE -1>=1 returns 0.
